// File: rtl/id_ex_pkg.sv
// Shared widths, control-field bit positions and the stage record layout
// for the ID/EX pipeline register.
package id_ex_pkg;

    localparam int WB_W   = 2;
    localparam int MEM_W  = 2;
    localparam int EX_W   = 4;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam int EX_ALUSRC   = 0;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_REGDST   = 3;
    localparam int MEM_WRITE   = 0;

    typedef struct packed {
        logic              valid;
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
        logic [EX_W-1:0]   ex;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rsdata;
        logic [DATA_W-1:0] rtdata;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rsaddr;
        logic [REG_W-1:0]  rtaddr;
        logic [REG_W-1:0]  rdaddr;
    } id_ex_rec_t;

endpackage

// File: rtl/id_ex_stage.sv
// One ID/EX register stage: falling-edge update, async active-low reset,
// hold, and bubble load. Control is zeroed whenever the stored valid is 0.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int PAY_W  = 143
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [PAY_W-1:0]  data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [PAY_W-1:0]  data_o
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
    logic [PAY_W-1:0]  data_q;

    // Gating control by valid keeps the "bubble never writes" invariant local.
    assign valid_d = valid_i & ~bubble_i;
    assign ctrl_d  = valid_d ? ctrl_i : '0;

    always_ff @(negedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (!hold_i) begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Parametrised ID/EX pipeline register: DEPTH chained stages with stall,
// flush (bubble at stage 0), valid tracking and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int WB_W   = id_ex_pkg::WB_W,
    parameter int MEM_W  = id_ex_pkg::MEM_W,
    parameter int EX_W   = id_ex_pkg::EX_W,
    parameter int DATA_W = id_ex_pkg::DATA_W,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [MEM_W-1:0]  mem_i,
    input  logic [EX_W-1:0]   ex_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rsdata_i,
    input  logic [DATA_W-1:0] rtdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rsaddr_i,
    input  logic [4:0]        rtaddr_i,
    input  logic [4:0]        rdaddr_i,
    output logic              valid_o,
    output logic [WB_W-1:0]   wb_o,
    output logic [MEM_W-1:0]  mem_o,
    output logic              memwrite_o,
    output logic              alusrc_o,
    output logic [1:0]        aluop_o,
    output logic              regdst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rsdata_o,
    output logic [DATA_W-1:0] rtdata_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [5:0]        funct_o,
    output logic [4:0]        rsaddr_o,
    output logic [4:0]        rtaddr_o,
    output logic [4:0]        rdaddr_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    import id_ex_pkg::*;

    localparam int CTRL_W = WB_W + MEM_W + EX_W;
    localparam int PAY_W  = 4 * DATA_W + 15;

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("id_ex_pipe_reg: DEPTH must be within 1..4");
    end
    if (EX_W < 4 || DATA_W < 6) begin : g_bad_width
        $error("id_ex_pipe_reg: EX_W must be >= 4 and DATA_W >= 6");
    end

    logic              valid_s [DEPTH+1];
    logic [CTRL_W-1:0] ctrl_s  [DEPTH+1];
    logic [PAY_W-1:0]  pay_s   [DEPTH+1];

    assign valid_s[0] = valid_i;
    assign ctrl_s[0]  = {wb_i, mem_i, ex_i};
    assign pay_s[0]   = {pc_i, rsdata_i, rtdata_i, imm_i, rsaddr_i, rtaddr_i, rdaddr_i};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        id_ex_stage #(
            .CTRL_W (CTRL_W),
            .PAY_W  (PAY_W)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .hold_i   (stall_i),
            .bubble_i ((gi == 0) ? flush_i : 1'b0),
            .valid_i  (valid_s[gi]),
            .ctrl_i   (ctrl_s[gi]),
            .data_i   (pay_s[gi]),
            .valid_o  (valid_s[gi+1]),
            .ctrl_o   (ctrl_s[gi+1]),
            .data_o   (pay_s[gi+1])
        );
    end

    logic [EX_W-1:0] ex_o;

    assign valid_o = valid_s[DEPTH];
    assign {wb_o, mem_o, ex_o} = ctrl_s[DEPTH];
    assign {pc_o, rsdata_o, rtdata_o, imm_o, rsaddr_o, rtaddr_o, rdaddr_o} = pay_s[DEPTH];

    assign memwrite_o = mem_o[MEM_WRITE];
    assign alusrc_o   = ex_o[EX_ALUSRC];
    assign aluop_o    = ex_o[EX_ALUOP_HI:EX_ALUOP_LO];
    assign regdst_o   = ex_o[EX_REGDST];
    assign funct_o    = imm_o[5:0];

    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counts bubbles actually inserted: a stalled flush inserts nothing.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!stall_i && flush_i && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

endmodule
